// File: rtl/set_injector_scheduler.sv
// Command FIFO: stores fixed-width entries in order; flush clears all entries.
// Latency: a push is visible at the head and in o_level one cycle after its edge.
// Backpressure: pushes are ignored while full or flushing; pops while empty are ignored.
module set_injector_scheduler_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop_vld,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             do_push;
    logic             do_pop;

    assign o_full     = (level_q == (AW+1)'(DEPTH));
    assign o_empty    = (level_q == '0);
    assign do_push    = i_push_vld & ~o_full & ~i_flush;
    assign do_pop     = i_pop_vld & ~o_empty & ~i_flush;
    assign o_head_dat = mem_q[rd_ptr_q];
    assign o_level    = level_q;

    always_comb begin
        level_d = level_q;
        if (i_flush)
            level_d = '0;
        else if (do_push & ~do_pop)
            level_d = level_q + 1'b1;
        else if (do_pop & ~do_push)
            level_d = level_q - 1'b1;
    end

    // Storage needs no reset: only entries below level_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= i_push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (i_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// Timed scheduler: queued (lane, value, delay) commands are written in order into a lane register bank.
// Latency: push at edge t into an idle, empty block writes the lane at edge t+2+delay.
// Backpressure: o_cmd_ready low while the FIFO is full or a flush is requested; sources must hold.
module set_injector_scheduler #(
    parameter int SET_SIZE    = 5,
    parameter int SET_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DELAY_WIDTH = 16,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [IDX_WIDTH-1:0]          i_cmd_idx,
    input  logic [SET_WIDTH-1:0]          i_cmd_value,
    input  logic [DELAY_WIDTH-1:0]        i_cmd_delay,
    input  logic                          i_pause,
    input  logic                          i_flush,
    output logic [SET_SIZE*SET_WIDTH-1:0] o_set_signals_asynch,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);
    typedef struct packed {
        logic [IDX_WIDTH-1:0]   idx;
        logic [SET_WIDTH-1:0]   value;
        logic [DELAY_WIDTH-1:0] delay;
    } cmd_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH:0] SET_SIZE_L = (IDX_WIDTH+1)'(SET_SIZE);

    cmd_t                          push_dat;
    cmd_t                          head_dat;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          pop_en;
    logic                          head_bad;

    state_t                        state_q;
    logic [DELAY_WIDTH-1:0]        counter_q;
    logic [IDX_WIDTH-1:0]          idx_q;
    logic [SET_WIDTH-1:0]          value_q;
    logic [SET_SIZE*SET_WIDTH-1:0] set_q;
    logic                          done_q;
    logic                          err_q;

    assign push_dat = '{idx: i_cmd_idx, value: i_cmd_value, delay: i_cmd_delay};
    assign pop_en   = (state_q == S_IDLE) & ~fifo_empty & ~i_flush;
    assign head_bad = ({1'b0, head_dat.idx} >= SET_SIZE_L);

    set_injector_scheduler_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (i_flush),
        .i_push_vld (i_cmd_valid),
        .i_push_dat (push_dat),
        .i_pop_vld  (pop_en),
        .o_head_dat (head_dat),
        .o_level    (o_fifo_level),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            idx_q     <= '0;
            value_q   <= '0;
            set_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_en) begin
                        if (head_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            idx_q     <= head_dat.idx;
                            value_q   <= head_dat.value;
                            counter_q <= head_dat.delay;
                            state_q   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Flush outranks pause; a paused command never fires, even at zero.
                    if (i_flush) begin
                        state_q <= S_IDLE;
                    end else if (!i_pause) begin
                        if (counter_q == '0) begin
                            for (int k = 0; k < SET_SIZE; k++) begin
                                if (idx_q == IDX_WIDTH'(k))
                                    set_q[k*SET_WIDTH +: SET_WIDTH] <= value_q;
                            end
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            counter_q <= counter_q - 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready          = ~fifo_full & ~i_flush;
    assign o_busy               = (state_q != S_IDLE) | ~fifo_empty;
    assign o_done               = done_q;
    assign o_err                = err_q;
    assign o_set_signals_asynch = set_q;
endmodule
